// File: rtl/writeback_sequencer.sv
// Writeback sequencer: serialises one retiring instruction's destination,
// address-register side-effect and PC update onto the register file's single
// write port. All outputs are registered.
// Optional: define WRITEBACK_FWD_EN to add the operand-bypass outputs.
module writeback_sequencer #(
    parameter  int WORD      = 16,
    parameter  int REGISTERS = 8,
    parameter  int PC        = 7,
    localparam int AW        = $clog2(REGISTERS),
    localparam int NB        = WORD / 8
) (
    input  logic            clk_i,
    input  logic            arst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            dst_en_i,
    input  logic [AW-1:0]   dst_addr_i,
    input  logic [WORD-1:0] dst_data_i,
    input  logic            byte_i,
    input  logic            load_i,
    input  logic            aux_en_i,
    input  logic [AW-1:0]   aux_addr_i,
    input  logic [WORD-1:0] aux_data_i,
    input  logic            pc_en_i,
    input  logic [WORD-1:0] pc_data_i,
    input  logic            mem_valid_i,
    input  logic [WORD-1:0] mem_data_i,
    input  logic            mem_lsb_i,
    output logic            wrEn_o,
    output logic [NB-1:0]   wrMode_o,
    output logic [AW-1:0]   wrAddr_o,
    output logic [WORD-1:0] data_o,
    output logic            pcEn_o,
    output logic [WORD-1:0] pc_o,
    output logic            done_o
`ifdef WRITEBACK_FWD_EN
   ,output logic            fwd_valid_o,
    output logic [AW-1:0]   fwd_addr_o,
    output logic [WORD-1:0] fwd_data_o,
    output logic [NB-1:0]   fwd_mode_o
`endif
);

    localparam logic [AW-1:0] PC_ADDR = AW'(PC);

    typedef enum logic [2:0] {IDLE, WAIT_MEM, WR_DST, WR_AUX, WR_PC} state_t;

    state_t state, state_n;

    // Captured request; aux_q/pc_q already have the conflict rules applied.
    logic [AW-1:0]   dst_addr_q, aux_addr_q;
    logic [WORD-1:0] dst_data_q, aux_data_q, pc_data_q;
    logic            byte_q, mem_lsb_q, aux_q, pc_q;

    // Request view: live inputs while idle (accept cycle), captured copy after.
    logic [AW-1:0]   r_dst_addr, r_aux_addr;
    logic [WORD-1:0] r_dst_data, r_aux_data, r_pc_data;
    logic            r_byte, r_lsb, r_aux, r_pc;

    logic            accept, idle, aux_eff, pc_eff;
    logic [WORD-1:0] dsrc;
    logic [7:0]      byte_lo;

    logic            wr_en_n, pc_en_n, done_n;
    logic [NB-1:0]   mode_n;
    logic [AW-1:0]   addr_n;
    logic [WORD-1:0] data_n, pc_n;

    assign idle        = (state == IDLE);
    assign req_ready_o = idle;
    assign accept      = req_valid_i && idle;

    // Same-register conflict: dst wins over aux. Any explicit write to PC
    // drops the pending PC update.
    assign aux_eff = aux_en_i && !(dst_en_i && (dst_addr_i == aux_addr_i));
    assign pc_eff  = pc_en_i && !(dst_en_i && (dst_addr_i == PC_ADDR))
                             && !(aux_eff && (aux_addr_i == PC_ADDR));

    assign r_dst_addr = idle ? dst_addr_i : dst_addr_q;
    assign r_aux_addr = idle ? aux_addr_i : aux_addr_q;
    assign r_dst_data = idle ? dst_data_i : dst_data_q;
    assign r_aux_data = idle ? aux_data_i : aux_data_q;
    assign r_pc_data  = idle ? pc_data_i  : pc_data_q;
    assign r_byte     = idle ? byte_i     : byte_q;
    assign r_lsb      = idle ? mem_lsb_i  : mem_lsb_q;
    assign r_aux      = idle ? aux_eff    : aux_q;
    assign r_pc       = idle ? pc_eff     : pc_q;

    // WR_DST is only entered from WAIT_MEM for loads, so the load word is taken
    // straight off the memory bus; byte loads pick the addressed byte.
    assign dsrc    = (state == WAIT_MEM) ? mem_data_i : r_dst_data;
    assign byte_lo = ((state == WAIT_MEM) && r_lsb) ? dsrc[15:8] : dsrc[7:0];

    // Next state and the write that the next state will present.
    always_comb begin
        state_n = state;
        wr_en_n = 1'b0;
        pc_en_n = 1'b0;
        done_n  = 1'b0;
        mode_n  = '0;
        addr_n  = '0;
        data_n  = '0;
        pc_n    = '0;
        case (state)
            IDLE: begin
                if (req_valid_i) begin
                    if (load_i && dst_en_i) state_n = WAIT_MEM;
                    else if (dst_en_i)      state_n = WR_DST;
                    else if (aux_eff)       state_n = WR_AUX;
                    else if (pc_eff)        state_n = WR_PC;
                    else                    done_n  = 1'b1;
                end
            end
            WAIT_MEM: if (mem_valid_i) state_n = WR_DST;
            WR_DST:   state_n = r_aux ? WR_AUX : (r_pc ? WR_PC : IDLE);
            WR_AUX:   state_n = r_pc ? WR_PC : IDLE;
            WR_PC:    state_n = IDLE;
            default:  state_n = IDLE;
        endcase
        case (state_n)
            WR_DST: begin
                wr_en_n = 1'b1;
                addr_n  = r_dst_addr;
                if (r_byte) begin
                    mode_n      = NB'(1);
                    data_n[7:0] = byte_lo;
                end else begin
                    mode_n = '1;
                    data_n = dsrc;
                end
                done_n = !r_aux && !r_pc;
            end
            WR_AUX: begin
                wr_en_n = 1'b1;
                addr_n  = r_aux_addr;
                mode_n  = '1;
                data_n  = r_aux_data;
                done_n  = !r_pc;
            end
            WR_PC: begin
                pc_en_n = 1'b1;
                pc_n    = r_pc_data;
                done_n  = 1'b1;
            end
            default: ;
        endcase
    end

    // Capture the request on accept; latch load data when it arrives.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            dst_addr_q <= '0;
            aux_addr_q <= '0;
            dst_data_q <= '0;
            aux_data_q <= '0;
            pc_data_q  <= '0;
            byte_q     <= 1'b0;
            mem_lsb_q  <= 1'b0;
            aux_q      <= 1'b0;
            pc_q       <= 1'b0;
        end else if (accept) begin
            dst_addr_q <= dst_addr_i;
            aux_addr_q <= aux_addr_i;
            dst_data_q <= dst_data_i;
            aux_data_q <= aux_data_i;
            pc_data_q  <= pc_data_i;
            byte_q     <= byte_i;
            mem_lsb_q  <= mem_lsb_i;
            aux_q      <= aux_eff;
            pc_q       <= pc_eff;
        end else if (state == WAIT_MEM && mem_valid_i) begin
            dst_data_q <= mem_data_i;
        end
    end

    // State register and registered register-file outputs.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state    <= IDLE;
            wrEn_o   <= 1'b0;
            wrMode_o <= '0;
            wrAddr_o <= '0;
            data_o   <= '0;
            pcEn_o   <= 1'b0;
            pc_o     <= '0;
            done_o   <= 1'b0;
        end else begin
            state    <= state_n;
            wrEn_o   <= wr_en_n;
            wrMode_o <= mode_n;
            wrAddr_o <= addr_n;
            data_o   <= data_n;
            pcEn_o   <= pc_en_n;
            pc_o     <= pc_n;
            done_o   <= done_n;
        end
    end

`ifdef WRITEBACK_FWD_EN
    // Bypass copy of the write being issued; a PC update forwards as a PC write.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            fwd_valid_o <= 1'b0;
            fwd_addr_o  <= '0;
            fwd_data_o  <= '0;
            fwd_mode_o  <= '0;
        end else begin
            fwd_valid_o <= wr_en_n || pc_en_n;
            fwd_addr_o  <= pc_en_n ? PC_ADDR : addr_n;
            fwd_data_o  <= pc_en_n ? pc_n    : data_n;
            fwd_mode_o  <= pc_en_n ? '1      : mode_n;
        end
    end
`endif

endmodule

// File: tb/tb_writeback_sequencer.sv
// Scoreboard bench for writeback_sequencer: directed requests push expected
// writes (with their cycle) into a queue; a monitor pops and compares.
module tb_writeback_sequencer;

    logic        clk_i = 1'b0;
    logic        arst_i;
    logic        req_valid_i, req_ready_o;
    logic        dst_en_i, byte_i, load_i, aux_en_i, pc_en_i, mem_valid_i, mem_lsb_i;
    logic [2:0]  dst_addr_i, aux_addr_i, wrAddr_o;
    logic [15:0] dst_data_i, aux_data_i, pc_data_i, mem_data_i, data_o, pc_o;
    logic        wrEn_o, pcEn_o, done_o;
    logic [1:0]  wrMode_o;

    writeback_sequencer dut (
        .clk_i(clk_i), .arst_i(arst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .dst_en_i(dst_en_i), .dst_addr_i(dst_addr_i), .dst_data_i(dst_data_i),
        .byte_i(byte_i), .load_i(load_i),
        .aux_en_i(aux_en_i), .aux_addr_i(aux_addr_i), .aux_data_i(aux_data_i),
        .pc_en_i(pc_en_i), .pc_data_i(pc_data_i),
        .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i), .mem_lsb_i(mem_lsb_i),
        .wrEn_o(wrEn_o), .wrMode_o(wrMode_o), .wrAddr_o(wrAddr_o), .data_o(data_o),
        .pcEn_o(pcEn_o), .pc_o(pc_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // kind: 0 register write, 1 PC update, 2 done-only (empty request)
    typedef struct {
        int          cyc;
        int          kind;
        logic [2:0]  addr;
        logic [1:0]  mode;
        logic [15:0] data;
        logic [15:0] mask;
        bit          done;
    } exp_t;

    exp_t sbq[$];
    exp_t me;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic exp_wr(input int c, input logic [2:0] a, input logic [1:0] m,
                          input logic [15:0] d, input logic [15:0] mk, input bit dn);
        sbq.push_back('{cyc: c, kind: 0, addr: a, mode: m, data: d, mask: mk, done: dn});
    endtask

    task automatic exp_pc(input int c, input logic [15:0] d);
        sbq.push_back('{cyc: c, kind: 1, addr: 3'd0, mode: 2'd0, data: d, mask: 16'hFFFF, done: 1'b1});
    endtask

    task automatic exp_done(input int c);
        sbq.push_back('{cyc: c, kind: 2, addr: 3'd0, mode: 2'd0, data: 16'h0, mask: 16'h0, done: 1'b1});
    endtask

    // Monitor: any enable or done on the output side must match the queue head.
    always @(negedge clk_i) begin
        if (!arst_i && (wrEn_o || pcEn_o || done_o)) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: wrEn=%b pcEn=%b done=%b addr=%0d data=%h pc=%h cycle %0d",
                         wrEn_o, pcEn_o, done_o, wrAddr_o, data_o, pc_o, cyc);
            end else begin
                me = sbq.pop_front();
                chk("cycle", 32'(cyc), 32'(me.cyc));
                chk("wrEn", 32'(wrEn_o), 32'(me.kind == 0));
                chk("pcEn", 32'(pcEn_o), 32'(me.kind == 1));
                chk("done", 32'(done_o), 32'(me.done));
                if (me.kind == 0) begin
                    chk("wrAddr", 32'(wrAddr_o), 32'(me.addr));
                    chk("wrMode", 32'(wrMode_o), 32'(me.mode));
                    chk("data", 32'(data_o & me.mask), 32'(me.data));
                end else if (me.kind == 1) begin
                    chk("pc", 32'(pc_o), 32'(me.data));
                end
            end
        end
    end

    // Wait (bounded) for an idle negedge; the request driven now is accepted
    // at the next posedge, whose cycle number is returned.
    task automatic wait_idle(output int acc);
        int n = 0;
        while (!req_ready_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (!req_ready_o) chk("ready_timeout", 32'(req_ready_o), 32'd1);
        acc = cyc + 1;
    endtask

    task automatic send(input bit de, input logic [2:0] da, input logic [15:0] dd,
                        input bit by, input bit ld,
                        input bit ae, input logic [2:0] aa, input logic [15:0] ad,
                        input bit pe, input logic [15:0] pd,
                        input bit lsb, input int mw, input logic [15:0] md);
        dst_en_i = de; dst_addr_i = da; dst_data_i = dd; byte_i = by; load_i = ld;
        aux_en_i = ae; aux_addr_i = aa; aux_data_i = ad;
        pc_en_i = pe; pc_data_i = pd; mem_lsb_i = lsb;
        req_valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        dst_en_i = 1'b0; aux_en_i = 1'b0; pc_en_i = 1'b0; load_i = 1'b0; byte_i = 1'b0;
        dst_data_i = 16'h0; aux_data_i = 16'h0; pc_data_i = 16'h0; mem_lsb_i = 1'b0;
        if (mw > 0) begin
            repeat (mw - 1) @(negedge clk_i);
            mem_valid_i = 1'b1;
            mem_data_i  = md;
            @(negedge clk_i);
            mem_valid_i = 1'b0;
            mem_data_i  = 16'h0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        arst_i = 1'b1;
        req_valid_i = 1'b0; dst_en_i = 1'b0; byte_i = 1'b0; load_i = 1'b0;
        aux_en_i = 1'b0; pc_en_i = 1'b0; mem_valid_i = 1'b0; mem_lsb_i = 1'b0;
        dst_addr_i = 3'd0; aux_addr_i = 3'd0;
        dst_data_i = 16'h0; aux_data_i = 16'h0; pc_data_i = 16'h0; mem_data_i = 16'h0;

        repeat (2) @(negedge clk_i);
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        chk("rst_wrEn", 32'(wrEn_o), 32'd0);
        chk("rst_pcEn", 32'(pcEn_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_wrMode", 32'(wrMode_o), 32'd0);
        chk("rst_data", 32'(data_o), 32'd0);
        chk("rst_pc", 32'(pc_o), 32'd0);
        arst_i = 1'b0;
        @(negedge clk_i);

        // Word ALU op to R3
        wait_idle(acc);
        exp_wr(acc, 3'd3, 2'b11, 16'h1234, 16'hFFFF, 1'b1);
        send(1, 3'd3, 16'h1234, 0, 0, 0, 3'd0, 16'h0, 0, 16'h0, 0, 0, 16'h0);
        chk("t1_busy", 32'(req_ready_o), 32'd0);
        @(negedge clk_i);
        chk("t1_ready_back", 32'(req_ready_o), 32'd1);

        // Byte load R2, high byte, memory answers after 3 cycles
        wait_idle(acc);
        exp_wr(acc + 3, 3'd2, 2'b01, 16'h00AB, 16'h00FF, 1'b1);
        send(1, 3'd2, 16'hFFFF, 1, 1, 0, 3'd0, 16'h0, 0, 16'h0, 1, 3, 16'hABCD);

        // Word load with post-inc and PC update
        wait_idle(acc);
        exp_wr(acc + 1, 3'd1, 2'b11, 16'h5A5A, 16'hFFFF, 1'b0);
        exp_wr(acc + 2, 3'd4, 2'b11, 16'h2002, 16'hFFFF, 1'b0);
        exp_pc(acc + 3, 16'h0104);
        send(1, 3'd1, 16'h0000, 0, 1, 1, 3'd4, 16'h2002, 1, 16'h0104, 0, 1, 16'h5A5A);

        // dst targets PC: PC update dropped
        wait_idle(acc);
        exp_wr(acc, 3'd7, 2'b11, 16'h0400, 16'hFFFF, 1'b1);
        send(1, 3'd7, 16'h0400, 0, 0, 0, 3'd0, 16'h0, 1, 16'h0102, 0, 0, 16'h0);

        // PC-only request
        wait_idle(acc);
        exp_pc(acc, 16'h0010);
        send(0, 3'd0, 16'h0, 0, 0, 0, 3'd0, 16'h0, 1, 16'h0010, 0, 0, 16'h0);

        // Byte ALU op R6
        wait_idle(acc);
        exp_wr(acc, 3'd6, 2'b01, 16'h00EF, 16'h00FF, 1'b1);
        send(1, 3'd6, 16'h12EF, 1, 0, 0, 3'd0, 16'h0, 0, 16'h0, 0, 0, 16'h0);

        // Same-register conflict: aux skipped
        wait_idle(acc);
        exp_wr(acc, 3'd5, 2'b11, 16'hAAAA, 16'hFFFF, 1'b1);
        send(1, 3'd5, 16'hAAAA, 0, 0, 1, 3'd5, 16'hBBBB, 0, 16'h0, 0, 0, 16'h0);

        // Aux-only then PC
        wait_idle(acc);
        exp_wr(acc, 3'd4, 2'b11, 16'h3000, 16'hFFFF, 1'b0);
        exp_pc(acc + 1, 16'h0200);
        send(0, 3'd0, 16'h0, 0, 0, 1, 3'd4, 16'h3000, 1, 16'h0200, 0, 0, 16'h0);

        // Aux targets PC: PC update dropped
        wait_idle(acc);
        exp_wr(acc, 3'd7, 2'b11, 16'h0300, 16'hFFFF, 1'b1);
        send(0, 3'd0, 16'h0, 0, 0, 1, 3'd7, 16'h0300, 1, 16'h0500, 0, 0, 16'h0);

        // Empty request: done only, one cycle after accept
        wait_idle(acc);
        exp_done(acc);
        send(0, 3'd0, 16'h0, 0, 0, 0, 3'd0, 16'h0, 0, 16'h0, 0, 0, 16'h0);

        // Stray mem_valid while idle must be ignored
        @(negedge clk_i);
        mem_valid_i = 1'b1; mem_data_i = 16'h7777;
        @(negedge clk_i);
        mem_valid_i = 1'b0; mem_data_i = 16'h0;

        // Byte load, low byte, memory answers after 2 cycles
        wait_idle(acc);
        exp_wr(acc + 2, 3'd2, 2'b01, 16'h00CD, 16'h00FF, 1'b1);
        send(1, 3'd2, 16'h0000, 1, 1, 0, 3'd0, 16'h0, 0, 16'h0, 0, 2, 16'hABCD);

        // Reset while waiting on memory: sequence aborted
        wait_idle(acc);
        send(1, 3'd3, 16'h0, 0, 1, 1, 3'd4, 16'h4444, 1, 16'h0600, 0, 0, 16'h0);
        @(negedge clk_i);
        chk("wait_busy", 32'(req_ready_o), 32'd0);
        arst_i = 1'b1;
        @(negedge clk_i);
        chk("abort_ready", 32'(req_ready_o), 32'd1);
        chk("abort_wrEn", 32'(wrEn_o), 32'd0);
        arst_i = 1'b0;
        @(negedge clk_i);
        mem_valid_i = 1'b1; mem_data_i = 16'h1111;
        @(negedge clk_i);
        mem_valid_i = 1'b0; mem_data_i = 16'h0;
        repeat (3) @(negedge clk_i);
        chk("abort_idle_ready", 32'(req_ready_o), 32'd1);
        chk("abort_no_pc", 32'(pcEn_o), 32'd0);

        repeat (3) @(negedge clk_i);
        chk("drain", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
